// File: rtl/mem8_pkg.sv
// mem8_pkg: state encoding and default widths shared by the mem8 arbiter.
package mem8_pkg;

  localparam int unsigned MEM8_AW = 8;
  localparam int unsigned MEM8_DW = 8;

  // 2'd3 is unused; the arbiter steers it back to IDLE.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/mem8_arb_rr_pick2.sv
// rr_pick2: combinational two-way pick returning a one-hot winner.
// With MEM8_ARB_RR_EN defined, contention goes to the requester not served
// last; otherwise requester 0 always wins and no last-served input exists.
module rr_pick2 (
  input  logic [1:0] req_i,
`ifdef MEM8_ARB_RR_EN
  input  logic       lastServed_i,
`endif
  output logic [1:0] pick_o
);

  // Choose a single winner among the active requests.
  always_comb begin
    pick_o = 2'b00;
`ifdef MEM8_ARB_RR_EN
    if (req_i == 2'b11) begin
      pick_o = lastServed_i ? 2'b01 : 2'b10;
    end else begin
      pick_o = req_i;
    end
`else
    if (req_i[0]) begin
      pick_o = 2'b01;
    end else if (req_i[1]) begin
      pick_o = 2'b10;
    end
`endif
  end

endmodule

// File: rtl/mem8_arb.sv
// mem8_arb: serialises two requesters onto one single-port synchronous memory.
// Every transaction runs IDLE -> ACCESS -> DONE. Define MEM8_ARB_RR_EN for
// round-robin arbitration; the default build uses fixed priority (req 0 wins).
module mem8_arb
  import mem8_pkg::*;
#(
  parameter int unsigned AW = MEM8_AW,
  parameter int unsigned DW = MEM8_DW
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [1:0]    req_i,
  input  logic [1:0]    we_i,
  input  logic [AW-1:0] addr0_i,
  input  logic [AW-1:0] addr1_i,
  input  logic [DW-1:0] wdata0_i,
  input  logic [DW-1:0] wdata1_i,
  output logic [1:0]    gnt_o,
  output logic [1:0]    ack_o,
  output logic [DW-1:0] rdata_o,
  output logic          busy_o,
  output logic          mem_en_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i
);

  state_e        state_q, state_d;
  logic [1:0]    pick;
  logic          launch;
  logic [1:0]    grant_q;
  logic          latWe_q;
  logic [AW-1:0] latAddr_q;
  logic [DW-1:0] latWdata_q;

  assign launch = (state_q == IDLE) && (|req_i);

`ifdef MEM8_ARB_RR_EN
  logic lastServed_q;

  rr_pick2 u_pick (
    .req_i        (req_i),
    .lastServed_i (lastServed_q),
    .pick_o       (pick)
  );

  // Remember who was served last; it moves when a transaction enters ACCESS.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lastServed_q <= 1'b1;
    end else if (launch) begin
      lastServed_q <= pick[1];
    end
  end
`else
  rr_pick2 u_pick (
    .req_i  (req_i),
    .pick_o (pick)
  );
`endif

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: any request starts a fixed three-cycle sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|req_i) state_d = ACCESS;
      ACCESS:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture the winner and its request fields; later changes are ignored.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      grant_q    <= 2'b00;
      latWe_q    <= 1'b0;
      latAddr_q  <= '0;
      latWdata_q <= '0;
    end else if (launch) begin
      grant_q <= pick;
      if (pick[1]) begin
        latWe_q    <= we_i[1];
        latAddr_q  <= addr1_i;
        latWdata_q <= wdata1_i;
      end else begin
        latWe_q    <= we_i[0];
        latAddr_q  <= addr0_i;
        latWdata_q <= wdata0_i;
      end
    end
  end

  // Outputs decode the state and the latched fields only, never req_i.
  always_comb begin
    gnt_o       = 2'b00;
    ack_o       = 2'b00;
    rdata_o     = '0;
    busy_o      = (state_q != IDLE);
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (state_q)
      ACCESS: begin
        gnt_o       = grant_q;
        mem_en_o    = 1'b1;
        mem_we_o    = latWe_q;
        mem_addr_o  = latAddr_q;
        mem_wdata_o = latWdata_q;
      end
      DONE: begin
        gnt_o = grant_q;
        ack_o = grant_q;
        if (!latWe_q) begin
          rdata_o = mem_rdata_i;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mem8_arb.sv
// tb_mem8_arb: directed scoreboard bench for mem8_arb with a behavioural
// single-port memory. Expected acks are queued when a request is driven and
// popped when the arbiter acknowledges.
module tb_mem8_arb;

  typedef struct packed {
    logic [1:0] who;
    logic [7:0] data;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [1:0] req;
  logic [1:0] we;
  logic [7:0] addr0, addr1, wdata0, wdata1;
  logic [1:0] gnt, ack;
  logic [7:0] rdata;
  logic       busy, memEn, memWe;
  logic [7:0] memAddr, memWdata;
  logic [7:0] memRdata;

  logic [7:0] memArr [256];
  logic       written [256];
  logic       memClear;

  exp_t sbQ[$];
  int   total;
  int   bad;
  int   memEnCount;
  int   enMark;
  logic [1:0] prevAck;

  mem8_arb dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_i       (req),
    .we_i        (we),
    .addr0_i     (addr0),
    .addr1_i     (addr1),
    .wdata0_i    (wdata0),
    .wdata1_i    (wdata1),
    .gnt_o       (gnt),
    .ack_o       (ack),
    .rdata_o     (rdata),
    .busy_o      (busy),
    .mem_en_o    (memEn),
    .mem_we_o    (memWe),
    .mem_addr_o  (memAddr),
    .mem_wdata_o (memWdata),
    .mem_rdata_i (memRdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Power-on contents of every location the bench never wrote.
  function automatic logic [7:0] initVal(input logic [7:0] a);
    return a ^ 8'hA5;
  endfunction

  // Behavioural synchronous memory: write or registered read when enabled.
  always @(posedge clk) begin
    if (memClear) begin
      for (int i = 0; i < 256; i++) written[i] <= 1'b0;
    end else if (memEn) begin
      if (memWe) begin
        memArr[memAddr]  <= memWdata;
        written[memAddr] <= 1'b1;
      end else begin
        memRdata <= written[memAddr] ? memArr[memAddr] : initVal(memAddr);
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] r, input logic [1:0] w,
                               input logic [7:0] a0, input logic [7:0] a1,
                               input logic [7:0] d0, input logic [7:0] d1);
    req    = r;
    we     = w;
    addr0  = a0;
    addr1  = a1;
    wdata0 = d0;
    wdata1 = d1;
  endtask

  function automatic logic [31:0] allOut();
    return 32'({gnt, ack, rdata, busy, memEn, memWe, memAddr, memWdata});
  endfunction

  // Advance to the next falling edge and score whatever the DUT shows there.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (memEn) memEnCount++;
    checkOutput("ack_twice", 32'(prevAck & ack), 32'd0);
    checkOutput("busy_vs_gnt", 32'(busy), 32'(gnt != 2'b00));
    if (ack != 2'b00) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpected_ack", 32'(ack), 32'd0);
      end else begin
        e = sbQ.pop_front();
        checkOutput("sb_ack", 32'(ack), 32'(e.who));
        checkOutput("sb_rdata", 32'(rdata), 32'(e.data));
      end
    end
    prevAck = ack;
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    memEnCount = 0;
    prevAck    = 2'b00;
    memClear   = 1'b1;
    rst_n      = 1'b0;
    applyStimulus(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);

    // Reset state, then five idle cycles.
    tick();
    tick();
    checkOutput("reset_outputs", allOut(), 32'd0);
    memClear = 1'b0;
    rst_n    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("idle_outputs", allOut(), 32'd0);
    end

    // Requester 0 writes 0x5A to 0x10, then reads it back.
    enMark = memEnCount;
    applyStimulus(2'b01, 2'b01, 8'h10, 8'h00, 8'h5A, 8'h00);
    sbQ.push_back('{who: 2'b01, data: 8'h00});
    tick();
    checkOutput("wr_gnt", 32'(gnt), 32'h1);
    checkOutput("wr_mem_en", 32'(memEn), 32'h1);
    checkOutput("wr_mem_we", 32'(memWe), 32'h1);
    checkOutput("wr_mem_addr", 32'(memAddr), 32'h10);
    checkOutput("wr_mem_wdata", 32'(memWdata), 32'h5A);
    tick();
    checkOutput("wr_ack", 32'(ack), 32'h1);
    checkOutput("wr_done_mem_en", 32'(memEn), 32'h0);
    applyStimulus(2'b01, 2'b00, 8'h10, 8'h00, 8'h00, 8'h00);
    sbQ.push_back('{who: 2'b01, data: 8'h5A});
    tick();
    checkOutput("idle_between_busy", 32'(busy), 32'h0);
    checkOutput("idle_between_gnt", 32'(gnt), 32'h0);
    tick();
    checkOutput("rd_mem_we", 32'(memWe), 32'h0);
    checkOutput("rd_mem_addr", 32'(memAddr), 32'h10);
    tick();
    checkOutput("rd_ack", 32'(ack), 32'h1);
    applyStimulus(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    tick();
    checkOutput("mem_en_per_txn", 32'(memEnCount - enMark), 32'd2);

    // Fresh reset so requester 0 wins the first contest.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Both requesters read continuously for four transaction slots.
    applyStimulus(2'b11, 2'b00, 8'h01, 8'h02, 8'h00, 8'h00);
`ifdef MEM8_ARB_RR_EN
    sbQ.push_back('{who: 2'b01, data: initVal(8'h01)});
    sbQ.push_back('{who: 2'b10, data: initVal(8'h02)});
    sbQ.push_back('{who: 2'b01, data: initVal(8'h01)});
    sbQ.push_back('{who: 2'b10, data: initVal(8'h02)});
`else
    for (int i = 0; i < 4; i++) sbQ.push_back('{who: 2'b01, data: initVal(8'h01)});
`endif
    for (int i = 0; i < 11; i++) tick();
    applyStimulus(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    tick();
    checkOutput("contention_drained", 32'(sbQ.size()), 32'd0);

    // Requester 1 changes its address after the grant.
    applyStimulus(2'b10, 2'b00, 8'h00, 8'h20, 8'h00, 8'h00);
    sbQ.push_back('{who: 2'b10, data: initVal(8'h20)});
    tick();
    applyStimulus(2'b10, 2'b00, 8'h00, 8'h30, 8'h00, 8'h00);
    #1;
    checkOutput("late_addr_gnt", 32'(gnt), 32'h2);
    checkOutput("late_addr_mem", 32'(memAddr), 32'h20);
    tick();
    applyStimulus(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    tick();

    // Reset in the middle of a write of 0xFF to 0x40.
    applyStimulus(2'b01, 2'b01, 8'h40, 8'h00, 8'hFF, 8'h00);
    tick();
    checkOutput("abort_mem_en_before", 32'(memEn), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_outputs_zero", allOut(), 32'd0);
    applyStimulus(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    tick();
    rst_n = 1'b1;
    tick();
    applyStimulus(2'b01, 2'b00, 8'h40, 8'h00, 8'h00, 8'h00);
    sbQ.push_back('{who: 2'b01, data: initVal(8'h40)});
    tick();
    tick();
    applyStimulus(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    tick();

    // Requester 0 drops req during ACCESS; the ack still arrives.
    applyStimulus(2'b01, 2'b00, 8'h05, 8'h00, 8'h00, 8'h00);
    sbQ.push_back('{who: 2'b01, data: initVal(8'h05)});
    tick();
    applyStimulus(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    tick();
    checkOutput("drop_ack", 32'(ack), 32'h1);
    tick();
    checkOutput("drop_busy", 32'(busy), 32'h0);

    checkOutput("scoreboard_empty", 32'(sbQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
